// File: rtl/codec_cfg_pkg.sv
// Shared constants for the audio codec configuration sequencer:
// register table, device address, volume limits, FSM states.
package codec_cfg_pkg;

  localparam logic [7:0] DEV_ADDR = 8'h34;

  localparam logic [3:0] IDX_FIRST = 4'd0;
  localparam logic [3:0] IDX_LHP   = 4'd4;
  localparam logic [3:0] IDX_RHP   = 4'd5;
  localparam logic [3:0] IDX_APATH = 4'd6;
  localparam logic [3:0] IDX_LAST  = 4'd9;

  localparam logic [6:0] R_LIN    = 7'h00;
  localparam logic [6:0] R_RIN    = 7'h01;
  localparam logic [6:0] R_LHP    = 7'h02;
  localparam logic [6:0] R_RHP    = 7'h03;
  localparam logic [6:0] R_APATH  = 7'h04;
  localparam logic [6:0] R_DPATH  = 7'h05;
  localparam logic [6:0] R_POWER  = 7'h06;
  localparam logic [6:0] R_IFACE  = 7'h07;
  localparam logic [6:0] R_ACTIVE = 7'h09;
  localparam logic [6:0] R_RESET  = 7'h0F;

  localparam logic [8:0] D_RESET  = 9'h000;
  localparam logic [8:0] D_POWER  = 9'h000;
  localparam logic [8:0] D_LINE   = 9'h017;
  localparam logic [8:0] D_DPATH  = 9'h000;
  localparam logic [8:0] D_IFACE  = 9'h042;
  localparam logic [8:0] D_ACTIVE = 9'h001;
  localparam logic [8:0] HP_BOTH  = 9'h080;
  localparam logic [8:0] AP_MIC   = 9'h014;
  localparam logic [8:0] AP_LINE  = 9'h012;

  localparam logic [6:0] VOL_MIN = 7'h30;
  localparam logic [6:0] VOL_MAX = 7'h7F;

  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_LOAD  = 3'd1;
  localparam state_t ST_SEND  = 3'd2;
  localparam state_t ST_WAIT  = 3'd3;
  localparam state_t ST_REL   = 3'd4;
  localparam state_t ST_DONE  = 3'd5;
  localparam state_t ST_ERROR = 3'd6;

  function automatic logic [6:0] vol_step(
    input logic [6:0] v
  );
    return (v == VOL_MAX) ? VOL_MIN : v + 7'd1;
  endfunction

  function automatic logic [23:0] cfg_word(
    input logic [3:0] idx,
    input logic [6:0] vol,
    input logic       mic
  );
    logic [6:0] ra;
    logic [8:0] d;
    ra = R_RESET;
    d  = D_RESET;
    case (idx)
      4'd1: begin ra = R_POWER;  d = D_POWER; end
      4'd2: begin ra = R_LIN;    d = D_LINE;  end
      4'd3: begin ra = R_RIN;    d = D_LINE;  end
      4'd4: begin
        ra = R_LHP;
        d  = HP_BOTH | {2'b00, vol};
      end
      4'd5: begin
        ra = R_RHP;
        d  = HP_BOTH | {2'b00, vol};
      end
      4'd6: begin
        ra = R_APATH;
        d  = mic ? AP_MIC : AP_LINE;
      end
      4'd7: begin ra = R_DPATH;  d = D_DPATH;  end
      4'd8: begin ra = R_IFACE;  d = D_IFACE;  end
      4'd9: begin ra = R_ACTIVE; d = D_ACTIVE; end
      default: begin ra = R_RESET; d = D_RESET; end
    endcase
    return {DEV_ADDR, ra, d};
  endfunction

endpackage

// File: rtl/codec_config_sequencer_watchdog.sv
// xfer_watchdog: counts WAIT_END cycles per transfer and retries.
// Ports: active/ack/clr in; timeout pulse and give_up out.
module xfer_watchdog #(
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int MAX_RETRY      = 3
) (
  input  logic clock,
  input  logic reset_n,
  input  logic active,
  input  logic ack,
  input  logic clr,
  output logic timeout,
  output logic give_up
);

  localparam int CW =
    (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int RW =
    (MAX_RETRY > 1) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [CW-1:0] CNT_END = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [RW-1:0] RTY_END = RW'(MAX_RETRY);

  logic [CW-1:0] cnt;
  logic [RW-1:0] retry;

  assign timeout = active && !ack && (cnt == CNT_END);
  assign give_up = timeout && (retry == RTY_END);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt   <= '0;
      retry <= '0;
    end else begin
      if (!active || timeout)
        cnt <= '0;
      else
        cnt <= cnt + CW'(1);
      if (clr || (active && ack))
        retry <= '0;
      else if (timeout && !give_up)
        retry <= retry + RW'(1);
    end
  end

endmodule

// File: rtl/codec_config_sequencer.sv
// Walks the codec register table over an i2c master (go/end_tr),
// then rewrites volume / input-select entries on request.
// Ports: start, vol_up, sel_mic, end_tr in; go, i2c_data, busy,
// done, error, volume out. CODEC_CFG_TIMEOUT_EN adds retry/error.
import codec_cfg_pkg::*;

module codec_config_sequencer #(
  parameter int         TIMEOUT_CYCLES = 4096,
  parameter int         MAX_RETRY      = 3,
  parameter logic [6:0] VOL_INIT       = 7'h79
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  input  logic        vol_up,
  input  logic        sel_mic,
  input  logic        end_tr,
  output logic        go,
  output logic [23:0] i2c_data,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [6:0]  volume
);

  if (TIMEOUT_CYCLES < 2 || MAX_RETRY < 0) begin : g_bad_param
    $error("codec_config_sequencer: bad timeout/retry setting");
  end

  state_t     state, state_n;
  logic [3:0] idx, idx_n;
  logic [3:0] last, last_n;
  logic       vol_pend, vol_pend_n;
  logic       rst_pend, rst_pend_n;
  logic       resend, resend_n;
  logic [6:0] vol_n;
  logic       mic_q, mic_applied, mic_pend;
  logic       full_go, next_job;
  logic       timeout, give_up;

  // The word last written to entry 6 is remembered, so a
  // sel_mic change during a run is caught once it ends.
  assign mic_pend = mic_q != mic_applied;

`ifdef CODEC_CFG_TIMEOUT_EN
  logic error_q;

  xfer_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .MAX_RETRY     (MAX_RETRY)
  ) u_wdog (
    .clock  (clock),
    .reset_n(reset_n),
    .active (state == ST_WAIT),
    .ack    (end_tr),
    .clr    (full_go),
    .timeout(timeout),
    .give_up(give_up)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)
      error_q <= 1'b0;
    else
      error_q <= state_n == ST_ERROR;
  end

  assign error = error_q;
`else
  assign timeout = 1'b0;
  assign give_up = 1'b0;
  assign error   = 1'b0;
`endif

  always_comb begin
    state_n    = state;
    idx_n      = idx;
    last_n     = last;
    resend_n   = resend;
    full_go    = 1'b0;
    next_job   = 1'b0;
    vol_n      = vol_up ? vol_step(volume) : volume;
    vol_pend_n = vol_pend | vol_up;
    rst_pend_n = rst_pend | start;
    unique case (state)
      ST_IDLE: full_go = 1'b1;
      ST_LOAD: state_n = ST_SEND;
      ST_SEND: state_n = ST_WAIT;
      ST_WAIT: begin
        if (end_tr) begin
          state_n  = ST_REL;
          resend_n = 1'b0;
        end else if (give_up) begin
          state_n = ST_ERROR;
        end else if (timeout) begin
          state_n  = ST_REL;
          resend_n = 1'b1;
        end
      end
      ST_REL: begin
        if (!end_tr) begin
          if (rst_pend_n) begin
            full_go = 1'b1;
          end else if (resend) begin
            state_n = ST_LOAD;
          end else if (idx != last) begin
            idx_n   = idx + 4'd1;
            state_n = ST_LOAD;
          end else begin
            next_job = 1'b1;
          end
        end
      end
      ST_DONE: begin
        if (start)
          full_go = 1'b1;
        else
          next_job = 1'b1;
      end
      ST_ERROR: begin
        if (rst_pend_n)
          full_go = 1'b1;
      end
      default: state_n = ST_IDLE;
    endcase

    if (full_go) begin
      state_n    = ST_LOAD;
      idx_n      = IDX_FIRST;
      last_n     = IDX_LAST;
      vol_pend_n = 1'b0;
      rst_pend_n = 1'b0;
      resend_n   = 1'b0;
    end else if (next_job) begin
      // Registered flag only: a vol_up landing this cycle is
      // already folded into vol_n and so into the word loaded.
      if (vol_pend) begin
        state_n    = ST_LOAD;
        idx_n      = IDX_LHP;
        last_n     = IDX_RHP;
        vol_pend_n = 1'b0;
      end else if (mic_pend) begin
        state_n = ST_LOAD;
        idx_n   = IDX_APATH;
        last_n  = IDX_APATH;
      end else begin
        state_n = ST_DONE;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      idx         <= IDX_FIRST;
      last        <= IDX_LAST;
      vol_pend    <= 1'b0;
      rst_pend    <= 1'b0;
      resend      <= 1'b0;
      volume      <= VOL_INIT;
      mic_q       <= 1'b0;
      mic_applied <= 1'b0;
      go          <= 1'b0;
      i2c_data    <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      state    <= state_n;
      idx      <= idx_n;
      last     <= last_n;
      vol_pend <= vol_pend_n;
      rst_pend <= rst_pend_n;
      resend   <= resend_n;
      volume   <= vol_n;
      mic_q    <= sel_mic;
      go       <= (state_n == ST_SEND) ||
                  (state_n == ST_WAIT);
      busy     <= !((state_n == ST_IDLE) ||
                    (state_n == ST_DONE) ||
                    (state_n == ST_ERROR));
      if (full_go)
        done <= 1'b0;
      else if (state_n == ST_DONE)
        done <= 1'b1;
      // Word is set on entry to LOAD, a cycle ahead of go.
      if (state_n == ST_LOAD) begin
        i2c_data <= cfg_word(idx_n, vol_n, mic_q);
        if (idx_n == IDX_APATH)
          mic_applied <= mic_q;
      end
    end
  end

endmodule

// File: tb/tb_codec_config_sequencer.sv
// Directed bench for codec_config_sequencer with an end_tr
// responder; timeout section built with CODEC_CFG_TIMEOUT_EN.
module tb_codec_config_sequencer;

  localparam int TO = 4096;

  logic        clock   = 1'b0;
  logic        reset_n = 1'b0;
  logic        start   = 1'b0;
  logic        vol_up  = 1'b0;
  logic        sel_mic = 1'b0;
  logic        end_tr  = 1'b0;
  logic        go;
  logic [23:0] i2c_data;
  logic        busy, done, error;
  logic [6:0]  volume;

  codec_config_sequencer dut (
    .clock   (clock),
    .reset_n (reset_n),
    .start   (start),
    .vol_up  (vol_up),
    .sel_mic (sel_mic),
    .end_tr  (end_tr),
    .go      (go),
    .i2c_data(i2c_data),
    .busy    (busy),
    .done    (done),
    .error   (error),
    .volume  (volume)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", tag, got, exp);
    end
  endtask

  logic [23:0] exp_tab [10] = '{
    24'h341E00, 24'h340C00, 24'h340017, 24'h340217,
    24'h3404F9, 24'h3406F9, 24'h340812, 24'h340A00,
    24'h340E42, 24'h341201
  };

  // end_tr responder: rises 20 cycles into go, drops after go
  logic resp_en = 1'b1;
  initial begin
    int cnt;
    cnt = 0;
    forever begin
      @(posedge clock);
      #1;
      if (end_tr) begin
        if (!go) end_tr = 1'b0;
      end else if (go && resp_en) begin
        if (cnt == 19) begin
          end_tr = 1'b1;
          cnt = 0;
        end else begin
          cnt++;
        end
      end else begin
        cnt = 0;
      end
    end
  end

  // bus monitor
  logic [23:0] words[$];
  int          rise_t[$];
  int          cyc = 0;
  int          glitch = 0, unstable = 0, early = 0;
  logic        watch_done = 1'b0, done_low = 1'b0;
  initial begin
    logic        go_d, end_d;
    logic [23:0] dat_d;
    go_d = 0; end_d = 0; dat_d = '0;
    forever begin
      @(negedge clock);
      cyc++;
      if (go && !go_d) begin
        words.push_back(i2c_data);
        rise_t.push_back(cyc);
        if (i2c_data !== dat_d) early++;
      end
      if (go && go_d && i2c_data !== dat_d) unstable++;
      if (!go && go_d && !end_d && reset_n) glitch++;
      if (watch_done && !done) done_low = 1'b1;
      go_d  = go;
      end_d = end_tr;
      dat_d = i2c_data;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic wait_idle(input string tag, input int lim);
    int n;
    n = 0;
    while (busy && n < lim) begin
      @(negedge clock);
      n++;
    end
    chk(tag, busy, 0);
  endtask

  task automatic pulse_start();
    @(negedge clock); start = 1'b1;
    @(negedge clock); start = 1'b0;
  endtask

  task automatic pulse_vol();
    @(negedge clock); vol_up = 1'b1;
    @(negedge clock); vol_up = 1'b0;
  endtask

  initial begin
    int n;
    tick(3);
    chk("rst_go", go, 0);
    chk("rst_data", i2c_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", error, 0);
    chk("rst_vol", volume, 7'h79);

    reset_n = 1'b1;
    tick(2);
    chk("run_busy", busy, 1);
    chk("run_done", done, 0);
    wait_idle("run1_end", 2000);
    chk("run1_cnt", words.size(), 10);
    for (int i = 0; i < 10; i++)
      chk($sformatf("run1_w%0d", i), words[i], exp_tab[i]);
    chk("run1_done", done, 1);
    chk("run1_err", error, 0);
    chk("run1_early", early, 0);
    chk("run1_stable", unstable, 0);

    words.delete();
    watch_done = 1'b1;
    done_low   = 1'b0;
    @(negedge clock); vol_up = 1'b1;
    @(negedge clock); vol_up = 1'b1;
    @(negedge clock); vol_up = 1'b0;
    tick(2);
    wait_idle("vol2_end", 500);
    chk("vol2_vol", volume, 7'h7B);
    chk("vol2_cnt", words.size(), 2);
    chk("vol2_w0", words[0], 24'h3404FB);
    chk("vol2_w1", words[1], 24'h3406FB);
    chk("vol2_held", done_low, 0);

    for (int i = 0; i < 4; i++) begin
      pulse_vol();
      tick(2);
      wait_idle("vol_step", 500);
    end
    chk("vol_max", volume, 7'h7F);
    words.delete();
    pulse_vol();
    tick(2);
    wait_idle("wrap_end", 500);
    chk("wrap_vol", volume, 7'h30);
    chk("wrap_cnt", words.size(), 2);
    chk("wrap_w0", words[0], 24'h3404B0);
    chk("wrap_w1", words[1], 24'h3406B0);

    words.delete();
    @(negedge clock); sel_mic = 1'b1;
    tick(3);
    wait_idle("mic_end", 500);
    chk("mic_cnt", words.size(), 1);
    chk("mic_w0", words[0], 24'h340814);
    chk("mic_held", done_low, 0);
    watch_done = 1'b0;

    words.delete();
    glitch = 0;
    pulse_start();
    n = 0;
    while (words.size() < 4 && n < 500) begin
      @(negedge clock);
      n++;
    end
    chk("rs_reach", words.size(), 4);
    pulse_start();
    chk("rs_done0", done, 0);
    chk("rs_err0", error, 0);
    wait_idle("rs_end", 3000);
    chk("rs_cnt", words.size(), 14);
    chk("rs_w3", words[3], 24'h340217);
    chk("rs_w4", words[4], 24'h341E00);
    chk("rs_w10", words[10], 24'h340814);
    chk("rs_w13", words[13], 24'h341201);
    chk("rs_glitch", glitch, 0);
    chk("rs_stable", unstable, 0);
    chk("rs_done", done, 1);

    pulse_start();
    n = 0;
    while (!go && n < 50) begin
      @(negedge clock);
      n++;
    end
    chk("mid_go", go, 1);
    @(negedge clock);
    #2 reset_n = 1'b0;
    #1;
    chk("mid_go0", go, 0);
    chk("mid_data", i2c_data, 0);
    chk("mid_busy", busy, 0);
    chk("mid_done", done, 0);
    chk("mid_vol", volume, 7'h79);
    words.delete();
    @(negedge clock); reset_n = 1'b1;
    tick(2);
    wait_idle("auto_end", 2000);
    chk("auto_cnt", words.size(), 10);
    chk("auto_w4", words[4], 24'h3404F9);
    chk("auto_w6", words[6], 24'h340814);
    chk("auto_done", done, 1);

`ifdef CODEC_CFG_TIMEOUT_EN
    resp_en = 1'b0;
    words.delete();
    rise_t.delete();
    pulse_start();
    n = 0;
    while (!error && n < 4 * (TO + 3) + 200) begin
      @(negedge clock);
      n++;
    end
    chk("to_err", error, 1);
    chk("to_busy", busy, 0);
    chk("to_cnt", words.size(), 4);
    for (int i = 1; i < 4; i++)
      chk($sformatf("to_gap%0d", i),
          rise_t[i] - rise_t[i-1], TO + 3);
    chk("to_w3", words[3], 24'h341E00);
    tick(20);
    chk("to_stay", error, 1);
    resp_en = 1'b1;
    pulse_start();
    tick(2);
    wait_idle("to_rec", 2000);
    chk("to_rec_err", error, 0);
    chk("to_rec_done", done, 1);
`else
    chk("err_tied", error, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/codec_config_sequencer.md
CODEC_CONFIG_SEQUENCER -- requirements
Module: codec_config_sequencer

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 4096: clock cycles allowed per transfer before retry.
REQ-002 SHALL have parameter MAX_RETRY, default 3: retries per register before error.
REQ-003 SHALL have parameter VOL_INIT, default 7'h79: headphone volume (0 dB) after reset.
REQ-004 SHALL have port clock, input, 1: single clock; all logic on its rising edge.
REQ-005 SHALL have port reset_n, input, 1: reset, asynchronous, active-low.
REQ-006 SHALL have port start, input, 1: single-cycle pulse that requests a full configuration run.
REQ-007 SHALL have port vol_up, input, 1: single-cycle pulse that steps the headphone volume.
REQ-008 SHALL have port sel_mic, input, 1: level input, 1 = microphone, 0 = line-in.
REQ-009 SHALL have port end_tr, input, 1: transfer-complete level from the i2c master.
REQ-010 SHALL have port go, output, 1: transfer request to the i2c master.
REQ-011 SHALL have port i2c_data, output, 24: {8'h34, reg[6:0], data[8:0]}.
REQ-012 SHALL have port busy, output, 1: high when not in IDLE, DONE or ERROR.
REQ-013 SHALL have port done, output, 1: full configuration completed.
REQ-014 SHALL have port error, output, 1: retries exhausted.
REQ-015 SHALL have port volume, output, 7: current headphone volume code.

Function
REQ-016 SHALL walk the 10-entry table in order: reset, power, L-in, R-in, L-HP, R-HP, analog path, digital path, interface, active.
REQ-017 SHALL substitute volume into the data of entries 4 and 5, giving 9'h080|volume (both-channel update bit set).
REQ-018 SHALL set entry 6 data to 9'h014 when sel_mic=1 and to 9'h012 when sel_mic=0.
REQ-019 SHALL use the states IDLE, LOAD, SEND, WAIT_END, RELEASE, DONE and ERROR.
REQ-020 SHALL, in LOAD, drive i2c_data one cycle before go rises and hold i2c_data stable until go falls.
REQ-021 SHALL hold go high through SEND and WAIT_END until end_tr=1, then drop go and enter RELEASE.
REQ-022 SHALL, in RELEASE, wait for end_tr=0 before advancing the index or starting the next transfer.
REQ-023 SHALL, after the last entry, enter DONE and set done=1; done SHALL stay 1 until reset or a new start.
REQ-024 SHALL, in DONE, rewrite only entries 4 and 5 in response to vol_up.
REQ-025 SHALL increment volume on vol_up; 7'h7F SHALL wrap to 7'h30.
REQ-026 SHALL, in DONE, rewrite only entry 6 on any change of the registered sel_mic.
REQ-027 SHALL, while busy, update volume immediately on vol_up and set a pending flag, with one rewrite per flag after the sequence ends.
REQ-028 SHALL, when start arrives while busy, finish the current transfer and then restart at index 0; start SHALL never abort mid-transfer.
REQ-029 SHALL give start priority over pending vol_up and sel_mic work when they occur simultaneously; a full run SHALL clear both pending flags.
REQ-030 SHALL leave done=0 and error=0 while the sequence runs.

Reset
REQ-031 SHALL, on reset_n=0, force the state to IDLE, go=0, i2c_data=0, busy=0, done=0, error=0 and volume=VOL_INIT, and clear the index, retry count and pending flags.
REQ-032 SHALL make reset effective immediately even mid-transfer, with go low in the same cycle reset asserts.
REQ-033 SHALL start a full run automatically on the first clock after reset release.

Configuration
REQ-034 SHALL, with CODEC_CFG_TIMEOUT_EN defined, count WAIT_END cycles.
REQ-035 SHALL, on a count of TIMEOUT_CYCLES, drop go and pass through RELEASE to resend the same entry.
REQ-036 SHALL, after MAX_RETRY failed retries, enter ERROR with error=1; ERROR SHALL be left only by start or reset.
REQ-037 SHALL, without CODEC_CFG_TIMEOUT_EN, wait indefinitely in WAIT_END, tie error to 0 and omit the counter logic.

Structure
REQ-038 SHALL keep the table constants, the device address 8'h34, the register indices, the analog-path codes, the volume limits 7'h30/7'h7F and the state enum in the shared package codec_cfg_pkg.
REQ-039 SHALL place the timeout/retry counter in the single sub-module xfer_watchdog, instantiated only under CODEC_CFG_TIMEOUT_EN.

Verification
REQ-040 SHALL check: release reset with sel_mic=0 and an end_tr model responding in 20 cycles -> 10 transfers, entry 4 = 24'h3404F9, entry 6 = 24'h340812, done=1.
REQ-041 SHALL check: in DONE, apply vol_up x2 -> volume=7'h7B, two transfers 24'h3404FB and 24'h3406FB, done held at 1.
REQ-042 SHALL check: set volume=7'h7F and apply vol_up -> volume=7'h30, transfers 24'h3404B0 and 24'h3406B0.
REQ-043 SHALL check: in DONE, toggle sel_mic to 1 -> exactly one transfer 24'h340814.
REQ-044 SHALL check: assert start during transfer 3 -> transfer 3 completes, then index 0 is resent; no go glitch occurs.
REQ-045 SHALL check, with CODEC_CFG_TIMEOUT_EN: end_tr stuck at 0 -> 4 go pulses spaced by TIMEOUT_CYCLES, then error=1 and busy=0.
